reservation_station_aged: RTL and testbench
===========================================

RESERVATION_STATION_AGED -- requirements
Module: reservation_station_aged

Interface
REQ-001 Parameter OPERANDS, 2, number of source operands per instruction.
REQ-002 Parameter RS_OFFSET, 0, global ID of entry 0; entry i has ID i+RS_OFFSET.
REQ-003 Parameter RS_DEPTH, 8, number of entries; at least 2.
REQ-004 Parameter RS_ID_WIDTH, 5, width of global station IDs.
REQ-005 Parameter CDB_PORTS, 2, number of result broadcast channels.
REQ-006 Parameter CONTROL_TYPE, add_sub_decode_t, per-instruction control payload type.
REQ-007 Port clk  in  1  clock; all state updates on its rising edge.
REQ-008 Port rst  in  1  reset, synchronous, active-high.
REQ-009 Port flush  in  1  discard all entries.
REQ-010 Port take_valid / take_ready  in / out  1 / 1  issue handshake.
REQ-011 Port op_value_valid_in, op_rs_id_in, op_value_in  in  [OPERANDS] x 1 / RS_ID_WIDTH / 32  issued operands, or producer tags when not valid.
REQ-012 Port control_in  in  CONTROL_TYPE  issued control payload.
REQ-013 Port id_taken  out  RS_ID_WIDTH  global ID the issued instruction is written to.
REQ-014 Port cdb_valid, cdb_tag, cdb_value  in  [CDB_PORTS] x 1 / RS_ID_WIDTH / 32  result broadcasts.
REQ-015 Port output_valid / output_ready  out / in  1 / 1  dispatch handshake.
REQ-016 Port op_value_out, control_out, op_rs_id_out  out  [OPERANDS] x 32 / CONTROL_TYPE / RS_ID_WIDTH  dispatched operands, control and global ID.
REQ-017 Port occupancy  out  $clog2(RS_DEPTH+1)  number of valid entries.

Function
REQ-018 Entry state: valid, control, per-operand value_valid/tag/value, and age.
  - age is $clog2(RS_DEPTH) bits and counts the valid entries older than this entry.
REQ-019 take_ready SHALL be 1 iff at least one entry is invalid in registered state.
  - A same-cycle dispatch does not free a slot for take.
REQ-020 id_taken SHALL be the lowest-index invalid entry plus RS_OFFSET, or RS_OFFSET when full.
REQ-021 On take_valid&take_ready&~flush, the selected entry SHALL be written with the issue data.
  - Its age SHALL be the occupancy after any same-cycle dispatch is removed.
REQ-022 Issue bypass: an operand issued not valid SHALL be stored valid with cdb_value[k] when cdb_valid[k] and cdb_tag[k] equal its tag in the same cycle.
REQ-023 Wake-up: every valid entry operand not yet valid SHALL capture cdb_value[k] when cdb_valid[k] and cdb_tag[k] match its tag.
  - Any CDB port may match any operand slot.
  - If several ports match, the lowest k wins.
REQ-024 An entry is ready when it is valid and all its operand value_valid bits are 1, in registered state.
  - Wake-up to dispatch latency is 1 cycle minimum.
  - Take to dispatch latency is 1 cycle minimum.
REQ-025 output_valid SHALL be 1 iff any entry is ready.
  - The selected entry is the ready entry with the smallest age (oldest first).
  - Outputs carry that entry's values, control and index+RS_OFFSET.
REQ-026 With output_valid=1 and output_ready=0, the selection MAY change to an older entry that becomes ready; data is not held stable.
REQ-027 On output_valid&output_ready&~flush, the selected entry SHALL be cleared.
  - Every valid entry with a larger age SHALL decrement its age by 1.
REQ-028 occupancy SHALL update by +1 on take, -1 on dispatch, and stay unchanged when both occur in the same cycle.
REQ-029 flush SHALL clear every valid bit and set occupancy to 0 at the next edge.
  - flush overrides take, dispatch and wake-up in that cycle.
  - Outputs remain combinational from state during the flush cycle.
REQ-030 Ages of valid entries SHALL always be a permutation of 0..occupancy-1.

Reset
REQ-031 rst SHALL clear all entry fields to 0, giving occupancy 0, take_ready 1, id_taken RS_OFFSET and output_valid 0 after the edge.
REQ-032 rst SHALL take priority over flush, take, dispatch and wake-up.
  - rst asserted mid-operation discards all entries with no dispatch.

Verification
REQ-033 RS_OFFSET=8: issue A (ops 1,2 valid), then B (op0 tag 3 pending), output_ready=0.
  - id_taken is 8 then 9.
  - output_valid rises the cycle after A is taken, presenting op_rs_id_out=8.
  - After cdb_tag=3/value 0x55 on port 1, B's op0 becomes 0x55.
REQ-034 Age order: fill entries 0..3 in order 2,0,3,1 (via dispatch-free holes), all pending, then wake all in one cycle.
  - Dispatch order is by issue order, not index.
REQ-035 Issue bypass: take with op1 tag 5 while cdb_valid[0]=1, tag 5, value 0xA.
  - Next cycle output_valid=1 and op_value_out[1]=0xA.
REQ-036 Full: RS_DEPTH takes, then take_valid with output_ready=1 and a ready entry.
  - take_ready=0 that cycle.
  - occupancy RS_DEPTH then RS_DEPTH-1.
  - The next cycle's take is accepted into the freed index.
REQ-037 Simultaneous take+dispatch keeps occupancy constant and ages a permutation.
  - flush with take_valid=1 leaves occupancy 0 and output_valid 0.
REQ-038 rst asserted with 3 ready entries and output_ready=1.
  - Next cycle output_valid=0 and occupancy=0.
  - Issued data reappears only after a new take.

Source files
------------

// File: rtl/reservation_station_aged_if.sv
// reservation_station_aged_if: control payload type and the issue/wake-up/dispatch bundle of the aged reservation station.
package reservation_station_aged_pkg;
  typedef struct packed {
    logic       sub;
    logic [2:0] op;
  } add_sub_decode_t;
endpackage

interface reservation_station_aged_if #(
  parameter int OPERANDS = 2,
  parameter int RS_DEPTH = 8,
  parameter int RS_ID_WIDTH = 5,
  parameter int CDB_PORTS = 2,
  parameter type CONTROL_TYPE = reservation_station_aged_pkg::add_sub_decode_t
);
  logic flush;
  logic take_valid, take_ready;
  logic [OPERANDS-1:0] op_value_valid_in;
  logic [OPERANDS-1:0][RS_ID_WIDTH-1:0] op_rs_id_in;
  logic [OPERANDS-1:0][31:0] op_value_in;
  CONTROL_TYPE control_in;
  logic [RS_ID_WIDTH-1:0] id_taken;
  logic [CDB_PORTS-1:0] cdb_valid;
  logic [CDB_PORTS-1:0][RS_ID_WIDTH-1:0] cdb_tag;
  logic [CDB_PORTS-1:0][31:0] cdb_value;
  logic output_valid, output_ready;
  logic [OPERANDS-1:0][31:0] op_value_out;
  CONTROL_TYPE control_out;
  logic [RS_ID_WIDTH-1:0] op_rs_id_out;
  logic [$clog2(RS_DEPTH+1)-1:0] occupancy;
  modport master (
    output flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
           cdb_valid, cdb_tag, cdb_value, output_ready,
    input  take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out, occupancy
  );
  modport slave (
    input  flush, take_valid, op_value_valid_in, op_rs_id_in, op_value_in, control_in,
           cdb_valid, cdb_tag, cdb_value, output_ready,
    output take_ready, id_taken, output_valid, op_value_out, control_out, op_rs_id_out, occupancy
  );
endinterface

// File: rtl/reservation_station_aged.sv
// reservation_station_aged: reservation station with CDB wake-up and oldest-ready-first dispatch.
module reservation_station_aged #(
  parameter int OPERANDS = 2,
  parameter int RS_OFFSET = 0,
  parameter int RS_DEPTH = 8,
  parameter int RS_ID_WIDTH = 5,
  parameter int CDB_PORTS = 2,
  parameter type CONTROL_TYPE = reservation_station_aged_pkg::add_sub_decode_t
) (
  input logic clk,
  input logic rst,
  reservation_station_aged_if.slave io
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int OW = $clog2(RS_DEPTH + 1);
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  CONTROL_TYPE [RS_DEPTH-1:0] ctrl_q, ctrl_d;
  logic [RS_DEPTH-1:0][OPERANDS-1:0] vv_q, vv_d;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][RS_ID_WIDTH-1:0] tag_q, tag_d;
  logic [RS_DEPTH-1:0][OPERANDS-1:0][31:0] val_q, val_d;
  logic [RS_DEPTH-1:0][AW-1:0] age_q, age_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [AW-1:0] free_idx, sel_idx, sel_age;
  logic sel_found, take, disp;
  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) free_idx = valid_q[i] ? free_idx : AW'(i);
  end
  // Ages are unique among valid entries, so the smallest ready age is the oldest ready entry.
  always_comb begin
    sel_found = 1'b0;
    sel_idx = '0;
    sel_age = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i] && &vv_q[i] && (!sel_found || age_q[i] < sel_age)) begin
        sel_found = 1'b1;
        sel_idx = AW'(i);
        sel_age = age_q[i];
      end
    end
  end
  assign io.take_ready = ~&valid_q;
  assign io.id_taken = RS_ID_WIDTH'(free_idx) + RS_ID_WIDTH'(RS_OFFSET);
  assign io.output_valid = sel_found;
  assign io.op_value_out = val_q[sel_idx];
  assign io.control_out = ctrl_q[sel_idx];
  assign io.op_rs_id_out = RS_ID_WIDTH'(sel_idx) + RS_ID_WIDTH'(RS_OFFSET);
  assign io.occupancy = occ_q;
  assign take = io.take_valid & io.take_ready & ~io.flush;
  assign disp = sel_found & io.output_ready & ~io.flush;
  always_comb begin
    valid_d = valid_q;
    ctrl_d = ctrl_q;
    vv_d = vv_q;
    tag_d = tag_q;
    val_d = val_q;
    age_d = age_q;
    occ_d = io.flush ? '0 : occ_q + OW'(take) - OW'(disp);
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int o = 0; o < OPERANDS; o++) begin
        for (int k = CDB_PORTS - 1; k >= 0; k--) begin
          if (valid_q[i] && !vv_q[i][o] && io.cdb_valid[k] && io.cdb_tag[k] == tag_q[i][o]) begin
            vv_d[i][o] = 1'b1;
            val_d[i][o] = io.cdb_value[k];
          end
        end
      end
      if (disp && valid_q[i] && age_q[i] > sel_age) age_d[i] = age_q[i] - 1'b1;
      if (disp && AW'(i) == sel_idx) valid_d[i] = 1'b0;
      if (take && AW'(i) == free_idx) begin
        valid_d[i] = 1'b1;
        ctrl_d[i] = io.control_in;
        age_d[i] = AW'(occ_q - OW'(disp));
        for (int o = 0; o < OPERANDS; o++) begin
          vv_d[i][o] = io.op_value_valid_in[o];
          tag_d[i][o] = io.op_rs_id_in[o];
          val_d[i][o] = io.op_value_in[o];
          for (int k = CDB_PORTS - 1; k >= 0; k--) begin
            if (!io.op_value_valid_in[o] && io.cdb_valid[k] && io.cdb_tag[k] == io.op_rs_id_in[o]) begin
              vv_d[i][o] = 1'b1;
              val_d[i][o] = io.cdb_value[k];
            end
          end
        end
      end
    end
    if (io.flush) valid_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      ctrl_q <= '0;
      vv_q <= '0;
      tag_q <= '0;
      val_q <= '0;
      age_q <= '0;
      occ_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
      vv_q <= vv_d;
      tag_q <= tag_d;
      val_q <= val_d;
      age_q <= age_d;
      occ_q <= occ_d;
    end
  end
endmodule

// File: tb/tb_reservation_station_aged.sv
// tb_reservation_station_aged: directed scenario tests of the aged reservation station (RS_OFFSET=8, depth 8).
module tb_reservation_station_aged;
  import reservation_station_aged_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  reservation_station_aged_if #(.OPERANDS(2), .RS_DEPTH(8), .RS_ID_WIDTH(5), .CDB_PORTS(2),
    .CONTROL_TYPE(add_sub_decode_t)) rif ();
  reservation_station_aged #(.OPERANDS(2), .RS_OFFSET(8), .RS_DEPTH(8), .RS_ID_WIDTH(5),
    .CDB_PORTS(2), .CONTROL_TYPE(add_sub_decode_t)) dut (.clk(clk), .rst(rst), .io(rif.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rif.flush = 0;
    rif.take_valid = 0;
    rif.op_value_valid_in = '0;
    rif.op_rs_id_in = '0;
    rif.op_value_in = '0;
    rif.control_in = '0;
    rif.cdb_valid = '0;
    rif.cdb_tag = '0;
    rif.cdb_value = '0;
    rif.output_ready = 0;
  endtask

  task automatic set_op(input int o, input logic v, input logic [31:0] x);
    rif.op_value_valid_in[o] = v;
    rif.op_rs_id_in[o] = x[4:0];
    rif.op_value_in[o] = x;
  endtask

  task automatic issue(input logic v0, input logic [31:0] x0, input logic v1, input logic [31:0] x1);
    set_op(0, v0, x0);
    set_op(1, v1, x1);
    rif.take_valid = 1;
    step();
    rif.take_valid = 0;
  endtask

  task automatic pop();
    rif.output_ready = 1;
    step();
    rif.output_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    clr();
    step();
    rst = 0;
    n_cmp++; if (rif.occupancy !== 4'd0) begin n_bad++; $display("FAIL reset_occupancy got %0d want 0", rif.occupancy); end
    n_cmp++; if (rif.take_ready !== 1'b1) begin n_bad++; $display("FAIL reset_take_ready got %b want 1", rif.take_ready); end
    n_cmp++; if (rif.id_taken !== 5'd8) begin n_bad++; $display("FAIL reset_id_taken got %0d want 8", rif.id_taken); end
    n_cmp++; if (rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL reset_output_valid got %b want 0", rif.output_valid); end
  endtask

  task automatic test_basic();
    n_cmp++; if (rif.id_taken !== 5'd8) begin n_bad++; $display("FAIL basic_id_a got %0d want 8", rif.id_taken); end
    rif.control_in = add_sub_decode_t'(4'hD);
    issue(1, 1, 1, 2);
    n_cmp++; if (rif.id_taken !== 5'd9) begin n_bad++; $display("FAIL basic_id_b got %0d want 9", rif.id_taken); end
    n_cmp++; if (rif.output_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_a got %b want 1", rif.output_valid); end
    n_cmp++; if (rif.op_rs_id_out !== 5'd8) begin n_bad++; $display("FAIL basic_rsid_a got %0d want 8", rif.op_rs_id_out); end
    n_cmp++; if (rif.op_value_out[1] !== 32'd2) begin n_bad++; $display("FAIL basic_val_a got %h want 2", rif.op_value_out[1]); end
    n_cmp++; if (rif.control_out !== add_sub_decode_t'(4'hD)) begin n_bad++; $display("FAIL basic_ctrl_a got %h want d", rif.control_out); end
    rif.control_in = add_sub_decode_t'(4'h2);
    issue(0, 3, 1, 7);
    n_cmp++; if (rif.occupancy !== 4'd2) begin n_bad++; $display("FAIL basic_occ got %0d want 2", rif.occupancy); end
    n_cmp++; if (rif.op_rs_id_out !== 5'd8) begin n_bad++; $display("FAIL basic_rsid_hold got %0d want 8", rif.op_rs_id_out); end
    rif.cdb_tag[0] = 5'd3;
    rif.cdb_value[0] = 32'hBAD;
    rif.cdb_valid = 2'b10;
    rif.cdb_tag[1] = 5'd3;
    rif.cdb_value[1] = 32'h55;
    step();
    rif.cdb_valid = '0;
    pop();
    n_cmp++; if (rif.op_rs_id_out !== 5'd9) begin n_bad++; $display("FAIL basic_rsid_b got %0d want 9", rif.op_rs_id_out); end
    n_cmp++; if (rif.op_value_out[0] !== 32'h55) begin n_bad++; $display("FAIL basic_wake_b got %h want 55", rif.op_value_out[0]); end
    n_cmp++; if (rif.op_value_out[1] !== 32'd7) begin n_bad++; $display("FAIL basic_op1_b got %h want 7", rif.op_value_out[1]); end
    n_cmp++; if (rif.control_out !== add_sub_decode_t'(4'h2)) begin n_bad++; $display("FAIL basic_ctrl_b got %h want 2", rif.control_out); end
    pop();
    n_cmp++; if (rif.occupancy !== 4'd0) begin n_bad++; $display("FAIL basic_drain got %0d want 0", rif.occupancy); end
    rif.control_in = '0;
  endtask

  task automatic test_age_order();
    logic [4:0] exp_id [4] = '{5'd10, 5'd8, 5'd11, 5'd9};
    issue(1, 32'h100, 1, 32'h101);
    issue(1, 32'h110, 1, 32'h111);
    n_cmp++; if (rif.id_taken !== 5'd10) begin n_bad++; $display("FAIL age_id_a got %0d want 10", rif.id_taken); end
    issue(0, 20, 1, 32'hA0);
    pop();
    n_cmp++; if (rif.id_taken !== 5'd8) begin n_bad++; $display("FAIL age_id_b got %0d want 8", rif.id_taken); end
    issue(0, 20, 1, 32'hA1);
    n_cmp++; if (rif.id_taken !== 5'd11) begin n_bad++; $display("FAIL age_id_c got %0d want 11", rif.id_taken); end
    issue(0, 20, 1, 32'hA2);
    pop();
    n_cmp++; if (rif.id_taken !== 5'd9) begin n_bad++; $display("FAIL age_id_d got %0d want 9", rif.id_taken); end
    issue(0, 20, 1, 32'hA3);
    n_cmp++; if (rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL age_pending got %b want 0", rif.output_valid); end
    rif.cdb_valid = 2'b01;
    rif.cdb_tag[0] = 5'd20;
    rif.cdb_value[0] = 32'h77;
    step();
    rif.cdb_valid = '0;
    rif.output_ready = 1;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (rif.op_rs_id_out !== exp_id[j] || rif.output_valid !== 1'b1) begin n_bad++; $display("FAIL age_order%0d got id %0d valid %b want id %0d", j, rif.op_rs_id_out, rif.output_valid, exp_id[j]); end
      n_cmp++; if (rif.op_value_out[1] !== 32'hA0 + j || rif.op_value_out[0] !== 32'h77) begin n_bad++; $display("FAIL age_data%0d got %h/%h want %h/77", j, rif.op_value_out[1], rif.op_value_out[0], 32'hA0 + j); end
      step();
    end
    rif.output_ready = 0;
    n_cmp++; if (rif.occupancy !== 4'd0) begin n_bad++; $display("FAIL age_drain got %0d want 0", rif.occupancy); end
  endtask

  task automatic test_bypass();
    rif.cdb_valid = 2'b11;
    rif.cdb_tag[0] = 5'd5;
    rif.cdb_value[0] = 32'hA;
    rif.cdb_tag[1] = 5'd5;
    rif.cdb_value[1] = 32'hB;
    issue(1, 3, 0, 5);
    rif.cdb_valid = '0;
    n_cmp++; if (rif.output_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid got %b want 1", rif.output_valid); end
    n_cmp++; if (rif.op_value_out[1] !== 32'hA) begin n_bad++; $display("FAIL bypass_value got %h want a", rif.op_value_out[1]); end
    pop();
    issue(0, 6, 1, 4);
    n_cmp++; if (rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL wake_pending got %b want 0", rif.output_valid); end
    rif.cdb_valid = 2'b11;
    rif.cdb_tag[0] = 5'd6;
    rif.cdb_value[0] = 32'hC;
    rif.cdb_tag[1] = 5'd6;
    rif.cdb_value[1] = 32'hD;
    step();
    rif.cdb_valid = '0;
    n_cmp++; if (rif.output_valid !== 1'b1 || rif.op_value_out[0] !== 32'hC) begin n_bad++; $display("FAIL wake_priority got %b/%h want 1/c", rif.output_valid, rif.op_value_out[0]); end
    pop();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) issue(1, 32'h10 + i, 1, 0);
    n_cmp++; if (rif.occupancy !== 4'd8) begin n_bad++; $display("FAIL full_occ got %0d want 8", rif.occupancy); end
    set_op(0, 1, 32'hEE);
    rif.take_valid = 1;
    rif.output_ready = 1;
    n_cmp++; if (rif.take_ready !== 1'b0) begin n_bad++; $display("FAIL full_take_ready got %b want 0", rif.take_ready); end
    step();
    rif.output_ready = 0;
    n_cmp++; if (rif.occupancy !== 4'd7) begin n_bad++; $display("FAIL full_occ_after got %0d want 7", rif.occupancy); end
    n_cmp++; if (rif.take_ready !== 1'b1 || rif.id_taken !== 5'd8) begin n_bad++; $display("FAIL full_freed got %b/%0d want 1/8", rif.take_ready, rif.id_taken); end
    step();
    rif.take_valid = 0;
    n_cmp++; if (rif.occupancy !== 4'd8) begin n_bad++; $display("FAIL full_refill got %0d want 8", rif.occupancy); end
    rif.output_ready = 1;
    for (int j = 0; j < 8; j++) begin
      n_cmp++; if (rif.op_rs_id_out !== (j < 7 ? 5'(9 + j) : 5'd8) || rif.op_value_out[0] !== (j < 7 ? 32'h11 + j : 32'hEE)) begin n_bad++; $display("FAIL full_drain%0d got %0d/%h", j, rif.op_rs_id_out, rif.op_value_out[0]); end
      step();
    end
    rif.output_ready = 0;
    n_cmp++; if (rif.occupancy !== 4'd0 || rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got %0d/%b want 0/0", rif.occupancy, rif.output_valid); end
  endtask

  task automatic test_back_to_back();
    issue(1, 32'h20, 1, 0);
    issue(1, 32'h21, 1, 0);
    n_cmp++; if (rif.id_taken !== 5'd10) begin n_bad++; $display("FAIL b2b_id got %0d want 10", rif.id_taken); end
    rif.output_ready = 1;
    issue(1, 32'h22, 1, 0);
    rif.output_ready = 0;
    n_cmp++; if (rif.occupancy !== 4'd2) begin n_bad++; $display("FAIL b2b_occ got %0d want 2", rif.occupancy); end
    n_cmp++; if (rif.op_rs_id_out !== 5'd9 || rif.op_value_out[0] !== 32'h21) begin n_bad++; $display("FAIL b2b_first got %0d/%h want 9/21", rif.op_rs_id_out, rif.op_value_out[0]); end
    pop();
    n_cmp++; if (rif.op_rs_id_out !== 5'd10 || rif.op_value_out[0] !== 32'h22) begin n_bad++; $display("FAIL b2b_second got %0d/%h want 10/22", rif.op_rs_id_out, rif.op_value_out[0]); end
    pop();
    issue(1, 32'h30, 1, 0);
    rif.flush = 1;
    rif.take_valid = 1;
    rif.output_ready = 1;
    step();
    clr();
    n_cmp++; if (rif.occupancy !== 4'd0 || rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL flush got %0d/%b want 0/0", rif.occupancy, rif.output_valid); end
    n_cmp++; if (rif.take_ready !== 1'b1 || rif.id_taken !== 5'd8) begin n_bad++; $display("FAIL flush_free got %b/%0d want 1/8", rif.take_ready, rif.id_taken); end
  endtask

  task automatic test_rst_mid();
    issue(1, 32'h40, 1, 0);
    issue(1, 32'h41, 1, 0);
    issue(1, 32'h42, 1, 0);
    n_cmp++; if (rif.occupancy !== 4'd3) begin n_bad++; $display("FAIL rst_pre got %0d want 3", rif.occupancy); end
    rst = 1;
    rif.output_ready = 1;
    step();
    rst = 0;
    n_cmp++; if (rif.output_valid !== 1'b0 || rif.occupancy !== 4'd0) begin n_bad++; $display("FAIL rst_mid got %b/%0d want 0/0", rif.output_valid, rif.occupancy); end
    step();
    n_cmp++; if (rif.output_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stays got %b want 0", rif.output_valid); end
    rif.output_ready = 0;
    issue(1, 32'h33, 1, 0);
    n_cmp++; if (rif.output_valid !== 1'b1 || rif.op_value_out[0] !== 32'h33 || rif.op_rs_id_out !== 5'd8) begin n_bad++; $display("FAIL rst_new got %b/%h/%0d want 1/33/8", rif.output_valid, rif.op_value_out[0], rif.op_rs_id_out); end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_age_order();
    test_bypass();
    test_full();
    test_back_to_back();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
